// File: rtl/matmul_pkg.sv
// Shared types and default widths for the matmul index sequencer.
package matmul_pkg;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_ADDR_WIDTH = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/matmul_index_gen_if.sv
// Beat bus between the index sequencer (master) and the MAC datapath (slave).
interface matmul_index_gen_if import matmul_pkg::*; #(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
);

  logic                  valid;
  logic                  ready;
  logic [ADDR_WIDTH-1:0] addr_a;
  logic [ADDR_WIDTH-1:0] addr_b;
  logic [ADDR_WIDTH-1:0] addr_c;
  logic [DATA_WIDTH-1:0] idx_i;
  logic [DATA_WIDTH-1:0] idx_j;
  logic [DATA_WIDTH-1:0] idx_k;
  logic                  first_k;
  logic                  last_k;

  modport master (
    output valid, addr_a, addr_b, addr_c, idx_i, idx_j, idx_k, first_k, last_k,
    input  ready
  );

  modport slave (
    input  valid, addr_a, addr_b, addr_c, idx_i, idx_j, idx_k, first_k, last_k,
    output ready
  );

endinterface

// File: rtl/wrap_counter.sv
// Loop index register: clear, increment, wrap to zero after reaching limit.
module wrap_counter #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr,
  input  logic                  inc,
  input  logic [DATA_WIDTH-1:0] limit,
  output logic [DATA_WIDTH-1:0] count,
  output logic                  wrap
);

  // wrap means the next increment rolls over; used as carry into the outer loop
  assign wrap = (count == limit);

  // clear wins over increment so a fresh run always starts at zero
  always_ff @(posedge clk) begin
    if (!rst_n)   count <= '0;
    else if (clr) count <= '0;
    else if (inc) count <= wrap ? '0 : count + 1'b1;
  end

endmodule

// File: rtl/matmul_index_gen.sv
// Loop-nest sequencer: walks i/j/k (k innermost) and issues A/B/C address
// beats. Every output is a flop; the beat after the current one is
// precomputed from the current indices and offset accumulators.
module matmul_index_gen import matmul_pkg::*; #(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] dim_m,
  input  logic [DATA_WIDTH-1:0] dim_n,
  input  logic [DATA_WIDTH-1:0] dim_p,
  input  logic [ADDR_WIDTH-1:0] base_a,
  input  logic [ADDR_WIDTH-1:0] base_b,
  input  logic [ADDR_WIDTH-1:0] base_c,
  output logic                  busy,
  output logic                  done,
  matmul_index_gen_if.master    bus
);

  localparam logic [DATA_WIDTH-1:0] ONE = DATA_WIDTH'(1);

  state_e state, state_nxt;

  logic [DATA_WIDTH-1:0] m_q, n_q, p_q;
  logic [ADDR_WIDTH-1:0] ba_q, bb_q, bc_q;
  logic [ADDR_WIDTH-1:0] off_in, off_ip, off_kp;  // i*N, i*P, k*P
  logic [ADDR_WIDTH-1:0] off_in_nxt, off_ip_nxt, off_kp_nxt;
  logic [ADDR_WIDTH-1:0] n_ext, p_ext;
  logic [DATA_WIDTH-1:0] i_cnt, j_cnt, k_cnt;
  logic [DATA_WIDTH-1:0] i_lim, j_lim, k_lim;
  logic [DATA_WIDTH-1:0] j_nxt, k_nxt;
  logic                  i_wrap, j_wrap, k_wrap;
  logic                  load, xfer, any_zero, last_beat, last_k_nxt;

  assign load      = (state == IDLE) && start;
  assign any_zero  = (dim_m == '0) || (dim_n == '0) || (dim_p == '0);
  assign xfer      = (state == RUN) && bus.valid && bus.ready;
  assign last_beat = i_wrap && j_wrap && k_wrap;

  assign i_lim = m_q - ONE;
  assign j_lim = p_q - ONE;
  assign k_lim = n_q - ONE;
  assign n_ext = ADDR_WIDTH'(n_q);
  assign p_ext = ADDR_WIDTH'(p_q);

  // Carry chain: k steps every transfer, j on k wrap, i on j and k wrap.
  wrap_counter #(.DATA_WIDTH(DATA_WIDTH)) u_cnt_k (
    .clk(clk), .rst_n(rst_n), .clr(load), .inc(xfer),
    .limit(k_lim), .count(k_cnt), .wrap(k_wrap)
  );
  wrap_counter #(.DATA_WIDTH(DATA_WIDTH)) u_cnt_j (
    .clk(clk), .rst_n(rst_n), .clr(load), .inc(xfer && k_wrap),
    .limit(j_lim), .count(j_cnt), .wrap(j_wrap)
  );
  wrap_counter #(.DATA_WIDTH(DATA_WIDTH)) u_cnt_i (
    .clk(clk), .rst_n(rst_n), .clr(load), .inc(xfer && k_wrap && j_wrap),
    .limit(i_lim), .count(i_cnt), .wrap(i_wrap)
  );

  assign bus.idx_i = i_cnt;
  assign bus.idx_j = j_cnt;
  assign bus.idx_k = k_cnt;

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next state: zero-sized runs skip straight to DONE; the last transfer ends RUN
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = any_zero ? DONE : RUN;
      RUN:     if (xfer && last_beat) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Precompute the following beat's indices and running offsets
  always_comb begin
    k_nxt      = k_wrap ? '0 : k_cnt + ONE;
    j_nxt      = k_wrap ? (j_wrap ? '0 : j_cnt + ONE) : j_cnt;
    off_kp_nxt = k_wrap ? '0 : off_kp + p_ext;
    off_in_nxt = (k_wrap && j_wrap) ? off_in + n_ext : off_in;
    off_ip_nxt = (k_wrap && j_wrap) ? off_ip + p_ext : off_ip;
    last_k_nxt = k_wrap ? (n_q == ONE) : (k_cnt + ONE == k_lim);
  end

  // Registered beat outputs: load on start, advance only on a transfer
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bus.valid   <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      bus.first_k <= 1'b0;
      bus.last_k  <= 1'b0;
      bus.addr_a  <= '0;
      bus.addr_b  <= '0;
      bus.addr_c  <= '0;
      m_q         <= '0;
      n_q         <= '0;
      p_q         <= '0;
      ba_q        <= '0;
      bb_q        <= '0;
      bc_q        <= '0;
      off_in      <= '0;
      off_ip      <= '0;
      off_kp      <= '0;
    end else begin
      bus.valid <= (state_nxt == RUN);
      busy      <= (state_nxt != IDLE);
      done      <= (state_nxt == DONE);
      if (load) begin
        m_q         <= dim_m;
        n_q         <= dim_n;
        p_q         <= dim_p;
        ba_q        <= base_a;
        bb_q        <= base_b;
        bc_q        <= base_c;
        off_in      <= '0;
        off_ip      <= '0;
        off_kp      <= '0;
        bus.addr_a  <= base_a;
        bus.addr_b  <= base_b;
        bus.addr_c  <= base_c;
        bus.first_k <= 1'b1;
        bus.last_k  <= (dim_n == ONE);
      end else if (xfer) begin
        off_in      <= off_in_nxt;
        off_ip      <= off_ip_nxt;
        off_kp      <= off_kp_nxt;
        bus.addr_a  <= ba_q + off_in_nxt + ADDR_WIDTH'(k_nxt);
        bus.addr_b  <= bb_q + off_kp_nxt + ADDR_WIDTH'(j_nxt);
        bus.addr_c  <= bc_q + off_ip_nxt + ADDR_WIDTH'(j_nxt);
        bus.first_k <= k_wrap;
        bus.last_k  <= last_k_nxt;
      end
    end
  end

endmodule

// File: tb/tb_matmul_index_gen.sv
// Randomized bench for matmul_index_gen against a triple-loop reference model.
module tb_matmul_index_gen;

  typedef struct packed {
    logic [7:0]  i, j, k;
    logic [15:0] a, b, c;
    logic        fk, lk;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  dim_m = '0, dim_n = '0, dim_p = '0;
  logic [15:0] base_a = '0, base_b = '0, base_c = '0;
  logic        busy, done;

  matmul_index_gen_if #(.DATA_WIDTH(8), .ADDR_WIDTH(16)) bus ();

  matmul_index_gen #(.DATA_WIDTH(8), .ADDR_WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .dim_m(dim_m), .dim_n(dim_n), .dim_p(dim_p),
    .base_a(base_a), .base_b(base_b), .base_c(base_c),
    .busy(busy), .done(done), .bus(bus)
  );

  always #5 clk = ~clk;

  int    n_chk = 0;
  int    n_fail = 0;
  beat_t exp_q[$];
  beat_t cap[$];
  bit    chk_en = 1'b0;
  int    rmode = 0;
  int    rcyc = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference: plain triple loop with multiplies, addresses mod 2^16
  function automatic void build(input int m, n, p, input logic [15:0] ba, bb, bc);
    beat_t bt;
    for (int i = 0; i < m; i++)
      for (int j = 0; j < p; j++)
        for (int k = 0; k < n; k++) begin
          bt.i  = 8'(i);
          bt.j  = 8'(j);
          bt.k  = 8'(k);
          bt.a  = 16'(int'(ba) + i * n + k);
          bt.b  = 16'(int'(bb) + k * p + j);
          bt.c  = 16'(int'(bc) + i * p + j);
          bt.fk = (k == 0);
          bt.lk = (k == n - 1);
          exp_q.push_back(bt);
        end
  endfunction

  // Ready driver: 0 = always high, 1 = pattern 1,0,0,1, 2 = random
  initial begin
    bus.ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (rmode)
        0:       bus.ready = 1'b1;
        1:       bus.ready = (rcyc % 4 == 0) || (rcyc % 4 == 3);
        default: bus.ready = 1'($urandom_range(0, 1));
      endcase
      rcyc++;
    end
  end

  // Compare process: every presented beat must equal the model's head
  initial begin
    beat_t cur;
    bit    fin_prev;
    fin_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (!chk_en) fin_prev = 1'b0;
      else begin
        if (fin_prev) begin
          check("done_after_last", done, 1);
          fin_prev = 1'b0;
        end
        if (bus.valid) begin
          cur = '{bus.idx_i, bus.idx_j, bus.idx_k, bus.addr_a, bus.addr_b,
                  bus.addr_c, bus.first_k, bus.last_k};
          check("busy_with_valid", busy, 1);
          n_chk++;
          if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_beat: got %h expected none", cur);
          end else begin
            if (cur !== exp_q[0]) begin
              n_fail++;
              $display("FAIL beat: got %h expected %h", cur, exp_q[0]);
            end
            if (bus.ready) begin
              void'(exp_q.pop_front());
              cap.push_back(cur);
              if (exp_q.size() == 0) fin_prev = 1'b1;
            end
          end
        end
      end
    end
  end

  task automatic run_mm(input int m, n, p, input logic [15:0] ba, bb, bc, input int mode);
    int bound;
    bit seen, nz;
    nz = (m > 0) && (n > 0) && (p > 0);
    exp_q.delete();
    cap.delete();
    build(m, n, p, ba, bb, bc);
    @(posedge clk);
    #1;
    dim_m = 8'(m); dim_n = 8'(n); dim_p = 8'(p);
    base_a = ba; base_b = bb; base_c = bc;
    start = 1'b1;
    rmode = mode;
    rcyc = 0;
    @(posedge clk);
    #1;
    start = 1'b0;
    // latched values must not follow the inputs
    dim_m = 8'($urandom); dim_n = 8'($urandom); dim_p = 8'($urandom);
    base_a = 16'($urandom); base_b = 16'($urandom); base_c = 16'($urandom);
    bound = m * n * p * 8 + 20;
    seen = 1'b0;
    for (int c = 0; c < bound; c++) begin
      @(negedge clk);
      if (c == 0) begin
        check("start_latency", bus.valid, nz);
        if (!nz) check("zero_dim_done", done, 1);
      end
      if (done) begin
        seen = 1'b1;
        check("done_valid_low", bus.valid, 0);
        break;
      end
      start = 1'($urandom_range(0, 1));  // ignored while busy
    end
    start = 1'b0;
    check("done_seen", seen, 1);
    check("beats_left", exp_q.size(), 0);
    check("beat_count", cap.size(), m * n * p);
    @(negedge clk);
    check("done_pulse_end", {done, busy, bus.valid}, 0);
  endtask

  task automatic pin_222();
    int ea[8] = '{0, 1, 0, 1, 2, 3, 2, 3};
    int eb[8] = '{'h10, 'h12, 'h11, 'h13, 'h10, 'h12, 'h11, 'h13};
    int ec[8] = '{'h20, 'h20, 'h21, 'h21, 'h22, 'h22, 'h23, 'h23};
    if (cap.size() == 8)
      for (int b = 0; b < 8; b++) begin
        check("a_seq", cap[b].a, ea[b]);
        check("b_seq", cap[b].b, eb[b]);
        check("c_seq", cap[b].c, ec[b]);
        check("fk_lk_seq", {cap[b].fk, cap[b].lk}, (b % 2 == 0) ? 2'b10 : 2'b01);
      end
  endtask

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_flags", {bus.valid, busy, done, bus.first_k, bus.last_k}, 0);
    check("reset_addr", {bus.addr_a, bus.addr_b, bus.addr_c}, 0);
    check("reset_idx", {bus.idx_i, bus.idx_j, bus.idx_k}, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk_en = 1'b1;

    run_mm(2, 2, 2, 16'h00, 16'h10, 16'h20, 0);
    pin_222();
    run_mm(2, 2, 2, 16'h00, 16'h10, 16'h20, 1);
    pin_222();
    run_mm(2, 0, 2, 16'h00, 16'h10, 16'h20, 0);

    run_mm(1, 1, 3, 16'h40, 16'h50, 16'h60, 0);
    if (cap.size() == 3)
      for (int b = 0; b < 3; b++) begin
        check("n1_fk_lk", {cap[b].fk, cap[b].lk}, 2'b11);
        check("n1_addr_c", cap[b].c, 16'h60 + b);
      end

    run_mm(2, 2, 2, 16'hFFFF, 16'h10, 16'h20, 0);
    if (cap.size() == 8) begin
      check("wrap_a0", cap[0].a, 16'hFFFF);
      check("wrap_a1", cap[1].a, 16'h0000);
    end

    // Reset in the middle of a run
    exp_q.delete();
    cap.delete();
    build(2, 2, 2, 16'h00, 16'h10, 16'h20);
    @(posedge clk);
    #1;
    dim_m = 8'd2; dim_n = 8'd2; dim_p = 8'd2;
    base_a = 16'h00; base_b = 16'h10; base_c = 16'h20;
    rmode = 0;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int c = 0; c < 40 && cap.size() < 3; c++) begin
      @(posedge clk);
      #2;
    end
    check("pre_reset_beats", cap.size(), 3);
    rst_n = 1'b0;
    @(posedge clk);
    #2;
    chk_en = 1'b0;
    exp_q.delete();
    @(negedge clk);
    check("midreset_flags", {bus.valid, busy, done, bus.first_k, bus.last_k}, 0);
    check("midreset_addr", {bus.addr_a, bus.addr_b, bus.addr_c}, 0);
    check("midreset_idx", {bus.idx_i, bus.idx_j, bus.idx_k}, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk_en = 1'b1;
    run_mm(2, 2, 2, 16'h00, 16'h10, 16'h20, 0);
    if (cap.size() == 8) check("restart_first", {cap[0].i, cap[0].j, cap[0].k, cap[0].a}, 0);

    // Randomized runs, random back-pressure
    for (int r = 0; r < 20; r++)
      run_mm($urandom_range(0, 4), $urandom_range(0, 4), $urandom_range(0, 4),
             16'($urandom), 16'($urandom), 16'($urandom), 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/matmul_index_gen.md
# matmul_index_gen

Loop-nest sequencer for the matrix-multiply datapath: on `start`, walks i (rows of A/C), j (cols of B/C), k (inner dimension) and issues one A/B/C address triple per beat over a valid/ready interface. It is the controlling end of the load/increment/clear index registers: it owns the counting decisions instead of receiving them. It also flags accumulator clear (`first_k`) and C write-back (`last_k`) so the MAC stage needs no loop logic of its own.

## Interface
- `DATA_WIDTH`, 8, width of dimensions and loop indices
- `ADDR_WIDTH`, 16, width of memory addresses and base offsets

- `clk` in 1: single clock, all logic on rising edge
- `rst_n` in 1: reset, synchronous, active-low
- `start` in 1: begin a run; sampled only in IDLE
- `dim_m`, `dim_n`, `dim_p` in DATA_WIDTH each: A is M×N, B is N×P, C is M×P, all row-major
- `base_a`, `base_b`, `base_c` in ADDR_WIDTH each: matrix base addresses
- `ready` in 1: downstream accepts the current beat
- `valid` out 1: beat present
- `addr_a`, `addr_b`, `addr_c` out ADDR_WIDTH each: beat addresses
- `idx_i`, `idx_j`, `idx_k` out DATA_WIDTH each: current loop indices
- `first_k` out 1: beat has k==0
- `last_k` out 1: beat has k==N-1
- `busy` out 1: high in RUN and DONE
- `done` out 1: one-cycle completion pulse

## Operation
- States: IDLE, RUN, DONE.
- IDLE with `start`=1:
  - Latch dims and bases.
  - If any dim is 0, go to DONE with no beats.
  - Otherwise go to RUN with i=j=k=0.
- RUN: `valid`=1. A beat transfers on `valid`&&`ready`. Loop order is k innermost, then j, then i:
  - k advances each transfer. At N-1, k wraps to 0 and j advances.
  - At j=P-1 with a k wrap, j wraps to 0 and i advances.
- Transfer with i=M-1, j=P-1, k=N-1: go to DONE.
- DONE: `done`=1 and `valid`=0 for exactly one cycle, then IDLE.
- Address arithmetic uses running offsets, with no multipliers:
  - `addr_a` = base_a + i·N + k
  - `addr_b` = base_b + k·P + j
  - `addr_c` = base_c + i·P + j
  - Offsets for i·N, i·P and k·P are kept as accumulators, added to or cleared on each index step.
  - All sums are modulo 2^ADDR_WIDTH. Overflow wraps silently.
- Beat count is exactly M·N·P.
- `first_k`/`last_k` are both high on a beat when N=1.
- `start` in RUN or DONE is ignored. Input dims and bases may change mid-run without effect, because they are latched.
- Reset is synchronous and may arrive mid-run: the next edge forces IDLE. All outputs and internal counters return to 0 and the run is abandoned without a `done` pulse.

## Timing
- Reset values: `valid`, `busy`, `done`, `first_k`, `last_k` = 0; all `addr_*` and `idx_*` = 0.
- Start latency: `start` sampled high in IDLE at edge t gives `valid`=1 with indices (0,0,0) from edge t+1.
- Zero-dim run: `done` from edge t+1.
- Back-pressure: while `valid`&&!`ready`, all beat outputs hold stable.
- Throughput: with `ready` held high, one beat per cycle and no bubbles across k/j/i wraps.
- Completion: `done` is asserted in the cycle after the final transfer.
- Restart: the earliest new `start` is sampled in the cycle after `done`.
- All outputs are registered, with no combinational path from `ready` or `start` to outputs. The next beat is precomputed.

## Structure
- Shared package `matmul_pkg`:
  - State enum (IDLE/RUN/DONE).
  - Default DATA_WIDTH/ADDR_WIDTH.
- Sub-module `wrap_counter` (DATA_WIDTH, inputs `clr`, `inc`, `limit`; outputs `count`, `wrap`):
  - Instantiated three times for i, j, k.
  - Carry chain: k.wrap drives j.inc; j.wrap&&k.wrap drives i.inc.
- Offset accumulators and the FSM live in the top level. Target 150–250 lines.

## Test plan
- M=N=P=2, bases 0x00/0x10/0x20, `ready`=1:
  - 8 consecutive beats.
  - `addr_a` sequence 0,1,0,1,2,3,2,3.
  - `addr_b` sequence 0x10,0x12,0x11,0x13,0x10,0x12,0x11,0x13.
  - `addr_c` sequence 0x20,0x20,0x21,0x21,0x22,0x22,0x23,0x23.
  - `first_k` on beats 0,2,4,6; `last_k` on beats 1,3,5,7.
  - `done` one cycle after beat 7.
- Same run with `ready` toggling 1,0,0,1…: outputs frozen during `ready`=0, same 8-beat sequence, no beat lost or duplicated.
- dim_n=0: `start` → `done` at t+1, `valid` never high, back to IDLE.
- M=1, N=1, P=3: 3 beats, each with `first_k`=`last_k`=1, `addr_c` = base_c+0,1,2.
- `rst_n`=0 asserted at beat 3 of a 2×2×2 run: next edge gives `valid`=`busy`=0 and all outputs 0, no `done`. A new `start` restarts at (0,0,0).
- base_a=0xFFFF, M=N=P=2, ADDR_WIDTH=16: `addr_a` wraps to 0x0000 on beat 1.
